// File: rtl/led_activity.sv
// Per-channel activity stretcher: synchronise, detect any toggle, and drive a
// fixed ON/OFF blink so short bursts of link activity stay visible on an LED.
module led_activity #(
    parameter int unsigned ON_CYCLES   = 3000000,
    parameter int unsigned OFF_CYCLES  = 3000000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_res,
    input  logic [1:0] i_rx_sig,
    input  logic [1:0] i_tx_sig,
    output logic [1:0] o_rx_led,
    output logic [1:0] o_tx_led
);

    localparam int unsigned NCH   = 4;
    localparam int unsigned MAXC  = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int unsigned CW    = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int unsigned PRIME = SYNC_STAGES + 1;
    localparam int unsigned PW    = $clog2(PRIME + 1);

    localparam logic [CW-1:0] ON_LOAD  = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] OFF_LOAD = CW'(OFF_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ON,
        S_OFF
    } state_t;

    logic [NCH-1:0]         sig;
    logic [SYNC_STAGES-1:0] sync [NCH];
    logic [NCH-1:0]         prev;
    logic [NCH-1:0]         act;
    logic [PW-1:0]          prime_cnt;
    logic                   primed;

    state_t                 state   [NCH];
    state_t                 state_n [NCH];
    logic [CW-1:0]          cnt     [NCH];
    logic [CW-1:0]          cnt_n   [NCH];
    logic [NCH-1:0]         pend;
    logic [NCH-1:0]         pend_n;
    logic [NCH-1:0]         led_d;
    logic [NCH-1:0]         led_q;

    assign sig    = {i_tx_sig, i_rx_sig};
    assign primed = (prime_cnt == PW'(PRIME));

    // Activity is masked until the synchronisers and prev register hold
    // post-reset samples, so inputs already high at release do not blink.
    always_comb begin
        act = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            act[i] = primed & (sync[i][SYNC_STAGES-1] ^ prev[i]);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            prime_cnt <= '0;
            prev      <= '0;
            pend      <= '0;
            led_q     <= '0;
            for (int unsigned i = 0; i < NCH; i++) begin
                sync[i]  <= '0;
                state[i] <= S_IDLE;
                cnt[i]   <= '0;
            end
        end else begin
            if (!primed) prime_cnt <= prime_cnt + PW'(1);
            pend  <= pend_n;
            led_q <= led_d;
            for (int unsigned i = 0; i < NCH; i++) begin
                sync[i]  <= {sync[i][SYNC_STAGES-2:0], sig[i]};
                prev[i]  <= sync[i][SYNC_STAGES-1];
                state[i] <= state_n[i];
                cnt[i]   <= cnt_n[i];
            end
        end
    end

    always_comb begin
        pend_n = pend;
        for (int unsigned i = 0; i < NCH; i++) begin
            state_n[i] = state[i];
            cnt_n[i]   = cnt[i];
            case (state[i])
                S_IDLE: begin
                    if (act[i]) begin
                        state_n[i] = S_ON;
                        cnt_n[i]   = ON_LOAD;
                    end
                end
                S_ON: begin
                    if (cnt[i] == '0) begin
                        state_n[i] = S_OFF;
                        cnt_n[i]   = OFF_LOAD;
                    end else begin
                        cnt_n[i] = cnt[i] - CW'(1);
                    end
                end
                S_OFF: begin
                    if (cnt[i] == '0) begin
                        pend_n[i] = 1'b0;
                        if (pend[i] | act[i]) begin
                            state_n[i] = S_ON;
                            cnt_n[i]   = ON_LOAD;
                        end else begin
                            state_n[i] = S_IDLE;
                        end
                    end else begin
                        cnt_n[i] = cnt[i] - CW'(1);
                        if (act[i]) pend_n[i] = 1'b1;
                    end
                end
                default: begin
                    state_n[i] = S_IDLE;
                    cnt_n[i]   = '0;
                    pend_n[i]  = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        led_d = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            led_d[i] = (state[i] == S_ON);
        end
    end

    assign o_rx_led = led_q[1:0];
    assign o_tx_led = led_q[3:2];

endmodule

// File: tb/tb_led_activity.sv
// Directed bench for led_activity with ON=4, OFF=3, SYNC=2.
module tb_led_activity;

    logic       clk = 1'b0;
    logic       i_res;
    logic [1:0] i_rx_sig;
    logic [1:0] i_tx_sig;
    logic [1:0] o_rx_led;
    logic [1:0] o_tx_led;
    logic [3:0] leds;

    int pass_cnt  = 0;
    int total_cnt = 0;

    led_activity #(
        .ON_CYCLES  (4),
        .OFF_CYCLES (3),
        .SYNC_STAGES(2)
    ) dut (
        .i_clk   (clk),
        .i_res   (i_res),
        .i_rx_sig(i_rx_sig),
        .i_tx_sig(i_tx_sig),
        .o_rx_led(o_rx_led),
        .o_tx_led(o_tx_led)
    );

    always #5 clk = ~clk;

    // bit order: {tx1, tx0, rx1, rx0}
    assign leds = {o_tx_led, o_rx_led};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        i_res    = 1'b1;
        i_rx_sig = 2'b00;
        i_tx_sig = 2'b00;
        tick();
        tick();
        i_res = 1'b0;
        repeat (6) tick();
    endtask

    task automatic test_reset;
        i_res    = 1'b1;
        i_rx_sig = 2'b00;
        i_tx_sig = 2'b00;
        for (int n = 0; n < 5; n++) begin
            i_rx_sig = ~i_rx_sig;
            i_tx_sig = ~i_tx_sig;
            tick();
            if (leds !== 4'b0000) $display("FAIL reset_hold n=%0d got %b want 0000", n, leds);
            else pass_cnt++;
            total_cnt++;
        end
        i_rx_sig = 2'b11;
        i_tx_sig = 2'b11;
        i_res    = 1'b0;
        for (int n = 0; n < 50; n++) begin
            tick();
            if (leds !== 4'b0000) $display("FAIL prime_static n=%0d got %b want 0000", n, leds);
            else pass_cnt++;
            total_cnt++;
        end
    endtask

    task automatic test_single_blink;
        logic [3:0] exp;
        do_reset();
        for (int n = 0; n < 16; n++) begin
            i_rx_sig[0] = (n == 0);
            tick();
            exp = (n >= 3 && n <= 6) ? 4'b0001 : 4'b0000;
            if (leds !== exp) $display("FAIL single_blink n=%0d got %b want %b", n, leds, exp);
            else pass_cnt++;
            total_cnt++;
        end
    endtask

    task automatic test_continuous;
        logic [3:0] exp;
        do_reset();
        for (int n = 0; n < 40; n++) begin
            i_tx_sig[1] = ~i_tx_sig[1];
            tick();
            exp = (n >= 3 && ((n - 3) % 7) < 4) ? 4'b1000 : 4'b0000;
            if (leds !== exp) $display("FAIL continuous n=%0d got %b want %b", n, leds, exp);
            else pass_cnt++;
            total_cnt++;
        end
        repeat (20) tick();
        if (leds !== 4'b0000) $display("FAIL continuous_drain got %b want 0000", leds);
        else pass_cnt++;
        total_cnt++;
    endtask

    // second toggle sampled at t2: 7 lands on the final OFF cycle, 8 one later
    task automatic test_boundary(input int t2);
        logic [3:0] exp;
        logic       hit;
        do_reset();
        for (int n = 0; n < 22; n++) begin
            i_rx_sig[1] = (n < t2);
            tick();
            if (t2 == 7) hit = (n >= 3 && n <= 6) || (n >= 10 && n <= 13);
            else         hit = (n >= 3 && n <= 6) || (n >= 11 && n <= 14);
            exp = hit ? 4'b0010 : 4'b0000;
            if (leds !== exp) $display("FAIL boundary_t%0d n=%0d got %b want %b", t2, n, leds, exp);
            else pass_cnt++;
            total_cnt++;
        end
    endtask

    task automatic test_pending;
        logic [3:0] exp;
        do_reset();
        for (int n = 0; n < 26; n++) begin
            i_tx_sig[0] = (n < 5);
            tick();
            exp = ((n >= 3 && n <= 6) || (n >= 10 && n <= 13)) ? 4'b0100 : 4'b0000;
            if (leds !== exp) $display("FAIL pending n=%0d got %b want %b", n, leds, exp);
            else pass_cnt++;
            total_cnt++;
        end
    endtask

    task automatic test_reset_mid_on;
        logic [3:0] exp;
        do_reset();
        for (int n = 0; n < 6; n++) begin
            i_rx_sig[0] = 1'b1;
            i_res       = (n == 5);
            tick();
            exp = (n == 3 || n == 4) ? 4'b0001 : 4'b0000;
            if (leds !== exp) $display("FAIL reset_mid_on n=%0d got %b want %b", n, leds, exp);
            else pass_cnt++;
            total_cnt++;
        end
        i_res = 1'b0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (leds !== 4'b0000) $display("FAIL after_reset_static n=%0d got %b want 0000", n, leds);
            else pass_cnt++;
            total_cnt++;
        end
        for (int n = 0; n < 10; n++) begin
            i_rx_sig[0] = 1'b0;
            tick();
            exp = (n >= 3 && n <= 6) ? 4'b0001 : 4'b0000;
            if (leds !== exp) $display("FAIL after_reset_toggle n=%0d got %b want %b", n, leds, exp);
            else pass_cnt++;
            total_cnt++;
        end
    endtask

    initial begin
        i_res    = 1'b1;
        i_rx_sig = 2'b00;
        i_tx_sig = 2'b00;
        test_reset();
        test_single_blink();
        test_continuous();
        test_boundary(7);
        test_boundary(8);
        test_pending();
        test_reset_mid_on();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
